data_mem_ws: RTL and testbench

- Parametrised, clocked successor to the MIPS single-cycle data RAM.
- Byte-addressed, little-endian, 32-bit words.
- Supports byte, half and word stores, and signed or unsigned byte and half loads.
- Request/done handshake with a configurable number of wait states, plus alignment and range error reporting; sits between the datapath MEM stage and the memory control logic.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_array.sv | 25 ++
 rtl/data_mem_ws.sv | 131 +++++++++++++
 tb/tb_data_mem_ws.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the wait-state data memory.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } dmem_state_e;

   function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: lane_enables = 4'b0001 << lane;
         SZ_HALF: lane_enables = lane[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: lane_enables = 4'b1111;
         default: lane_enables = 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic unsigned_ld);
      logic [31:0] bsh;
      logic [31:0] hsh;
      bsh = word >> {lane, 3'b000};
      hsh = word >> {lane[1], 4'b0000};
      case (size)
         SZ_BYTE: load_extend = {{24{~unsigned_ld & bsh[7]}}, bsh[7:0]};
         SZ_HALF: load_extend = {{16{~unsigned_ld & hsh[15]}}, hsh[15:0]};
         default: load_extend = word;
      endcase
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port byte-writable synchronous RAM with registered read data; storage is not reset.
module dmem_array #(
   parameter int unsigned Depth = 256,
   localparam int unsigned IdxW = $clog2(Depth)
) (
   input  logic            clk_i,
   input  logic            we_i,
   input  logic [3:0]      be_i,
   input  logic [IdxW-1:0] idx_i,
   input  logic [31:0]     wdata_i,
   output logic [31:0]     rdata_o
);

   logic [31:0] mem [Depth];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
      rdata_o <= mem[idx_i];
   end

endmodule

// File: rtl/data_mem_ws.sv
// Clocked data memory with req/done handshake, programmable wait states and
// alignment/range/illegal-size rejection.
module data_mem_ws
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS) + 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        unsigned_ld,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int unsigned IW = AW - 2;

   dmem_state_e state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        accept, misalign, out_of_range, illegal, req_err;

   logic          we_q, uns_q, err_q;
   logic [1:0]    size_q, lane_q;
   logic [IW-1:0] idx_q;
   logic [31:0]   wdata_q, rdata_q;

   logic          ram_we;
   logic [3:0]    ram_be;
   logic [IW-1:0] ram_idx;
   logic [31:0]   ram_wdata, ram_rdata;

   always_comb begin
      misalign     = ((size == SZ_HALF) && addr[0]) || ((size == SZ_WORD) && (addr[1:0] != 2'b00));
      out_of_range = |(addr >> AW);
      illegal      = (size == 2'b11);
      req_err      = misalign || out_of_range || illegal;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               accept = 1'b1;
               if (req_err || (WAIT_STATES == 0)) begin
                  state_d = StResp;
               end else begin
                  state_d = StWait;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) state_d = StResp;
            else               cnt_d   = cnt_q - 4'd1;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= we;
         size_q  <= size;
         uns_q   <= unsigned_ld;
         lane_q  <= addr[1:0];
         idx_q   <= addr[AW-1:2];
         wdata_q <= wdata;
         err_q   <= req_err;
      end
   end

   // Read the word on the accept edge so the registered RAM output is ready
   // in the done cycle even with zero wait states.
   always_comb begin
      ram_idx = (state_q == StIdle) ? addr[AW-1:2] : idx_q;
      ram_we  = (state_q == StResp) && we_q && !err_q && !reset;
      ram_be  = lane_enables(size_q, lane_q);
      case (size_q)
         SZ_BYTE: ram_wdata = {4{wdata_q[7:0]}};
         SZ_HALF: ram_wdata = {2{wdata_q[15:0]}};
         default: ram_wdata = wdata_q;
      endcase
   end

   dmem_array #(
      .Depth(DEPTH_WORDS)
   ) u_array (
      .clk_i  (clk),
      .we_i   (ram_we),
      .be_i   (ram_be),
      .idx_i  (ram_idx),
      .wdata_i(ram_wdata),
      .rdata_o(ram_rdata)
   );

   always_comb begin
      busy  = (state_q != StIdle);
      done  = (state_q == StResp);
      err   = done && err_q;
      rdata = rdata_q;
      if (done) begin
         if (err_q)      rdata = 32'd0;
         else if (!we_q) rdata = load_extend(ram_rdata, size_q, lane_q, uns_q);
      end
   end

endmodule

// File: tb/tb_data_mem_ws.sv
// Randomized and directed bench for data_mem_ws; index 0 is a 2-wait-state instance,
// index 1 a zero-wait-state instance, both checked against a byte-array model.
module tb_data_mem_ws;

   logic        clk;
   logic        rst   [2];
   logic        req   [2];
   logic        we    [2];
   logic        uns   [2];
   logic [1:0]  size  [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic        busy  [2];
   logic        done  [2];
   logic        err   [2];
   logic [31:0] rdata [2];

   logic [7:0] ref_mem [2][1024];
   int checks = 0;
   int errors = 0;

   data_mem_ws #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_dut_ws2 (
      .clk(clk), .reset(rst[0]), .req(req[0]), .we(we[0]), .size(size[0]),
      .unsigned_ld(uns[0]), .addr(addr[0]), .wdata(wdata[0]), .busy(busy[0]),
      .done(done[0]), .rdata(rdata[0]), .err(err[0])
   );

   data_mem_ws #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut_ws0 (
      .clk(clk), .reset(rst[1]), .req(req[1]), .we(we[1]), .size(size[1]),
      .unsigned_ld(uns[1]), .addr(addr[1]), .wdata(wdata[1]), .busy(busy[1]),
      .done(done[1]), .rdata(rdata[1]), .err(err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'b11) || ((a & ((32'd1 << sz) - 32'd1)) != 32'd0) || (a >= 32'd1024);
   endfunction

   function automatic logic [31:0] ref_load(input int d, input logic [31:0] a, input logic [1:0] sz,
                                            input logic u);
      int n;
      logic [31:0] v;
      n = 1 << sz;
      v = 32'd0;
      for (int k = 0; k < n; k++) v = v | (32'(ref_mem[d][a[9:0] + 10'(k)]) << (8 * k));
      if (!u && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      return v;
   endfunction

   task automatic ref_store(input int d, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] wd);
      for (int k = 0; k < (1 << sz); k++) ref_mem[d][a[9:0] + 10'(k)] = wd[8*k +: 8];
   endtask

   // One full request: drive, accept, scramble inputs while busy, wait for done.
   task automatic run_txn(input int d, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
      logic [31:0] exp_rd;
      bit          exp_err;
      bit          seen;
      bit          busy_ok;
      int          lat;
      int          exp_lat;
      exp_err = model_err(sz, a);
      exp_rd  = exp_err ? 32'd0 : ref_load(d, a, sz, u);
      exp_lat = exp_err ? 1 : ((d == 0) ? 3 : 1);
      @(negedge clk);
      req[d] = 1'b1; we[d] = w; size[d] = sz; uns[d] = u; addr[d] = a; wdata[d] = wd;
      @(posedge clk);
      lat = 0; seen = 0; busy_ok = 1;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         req[d]   = 1'b0;
         we[d]    = 1'($urandom);
         size[d]  = 2'($urandom);
         uns[d]   = 1'($urandom);
         addr[d]  = $urandom;
         wdata[d] = $urandom;
         if (busy[d] !== 1'b1) busy_ok = 0;
         if (done[d] === 1'b1) seen = 1;
      end
      rd = rdata[d];
      check_eq("latency", 32'(lat), 32'(exp_lat));
      check_eq("busy_window", 32'(busy_ok), 32'd1);
      check_eq("err", 32'(err[d]), 32'(exp_err));
      if (!w || exp_err) check_eq("rdata", rd, exp_rd);
      if (w && !exp_err) ref_store(d, a, sz, wd);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] old;
      logic [31:0] ba;
      logic [31:0] exp;
      logic [31:0] a;
      logic [1:0]  sz;
      int          r;

      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; uns[d] = 1'b0;
         size[d] = 2'b00; addr[d] = 32'd0; wdata[d] = 32'd0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check_eq("rst_busy", 32'(busy[d]), 32'd0);
         check_eq("rst_done", 32'(done[d]), 32'd0);
         check_eq("rst_err", 32'(err[d]), 32'd0);
         check_eq("rst_rdata", rdata[d], 32'd0);
         rst[d] = 1'b0;
      end

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 256; i++) run_txn(d, 1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, rd);

      run_txn(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd);
      run_txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd);
      check_eq("ld_word", rd, 32'hDEADBEEF);
      run_txn(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000007F, rd);
      run_txn(0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd);
      check_eq("ld_sbyte_7f", rd, 32'h0000007F);
      run_txn(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, rd);
      run_txn(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd);
      check_eq("ld_sbyte_80", rd, 32'hFFFFFF80);
      run_txn(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd);
      check_eq("ld_ubyte_80", rd, 32'h00000080);
      run_txn(0, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, rd);
      check_eq("ld_uhalf", rd, 32'h00007FEF);

      run_txn(0, 1'b1, 2'b01, 1'b0, 32'h21, 32'h1234, rd);
      run_txn(0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h5555AAAA, rd);
      run_txn(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd);
      run_txn(0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, rd);
      run_txn(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd);

      // Reset while the store to 0x8 is still waiting: it must never land.
      old = ref_load(0, 32'h8, 2'b10, 1'b0);
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b1; size[0] = 2'b10; addr[0] = 32'h8; wdata[0] = ~old;
      @(posedge clk);
      @(negedge clk);
      req[0] = 1'b0; rst[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("rstmid_busy", 32'(busy[0]), 32'd0);
      check_eq("rstmid_done", 32'(done[0]), 32'd0);
      rst[0] = 1'b0;
      run_txn(0, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd);
      check_eq("rstmid_old", rd, old);

      // Zero wait states, req held high: completions on every second cycle.
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check_eq("b2b_idle", 32'(done[1]), 32'd0);
         ba = 32'($urandom_range(0, 255)) * 32'd4;
         exp = ref_load(1, ba, 2'b10, 1'b0);
         req[1] = 1'b1; we[1] = 1'b0; size[1] = 2'b10; uns[1] = 1'b0; addr[1] = ba;
         @(negedge clk);
         check_eq("b2b_done", 32'(done[1]), 32'd1);
         check_eq("b2b_rdata", rdata[1], exp);
         check_eq("b2b_err", 32'(err[1]), 32'd0);
         we[1] = 1'b1; size[1] = 2'($urandom); addr[1] = $urandom; wdata[1] = $urandom;
         @(negedge clk);
      end
      req[1] = 1'b0;

      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 200; n++) begin
            r  = $urandom_range(0, 9);
            a  = 32'($urandom_range(0, 1023));
            sz = (r == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (r >= 2) a = a & ~((32'd1 << sz) - 32'd1);
            if (r == 1) a = a | (32'h400 << $urandom_range(0, 21));
            run_txn(d, 1'($urandom), sz, 1'($urandom), a, $urandom, rd);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
